viterbi_frame_ctrl: RTL

Frame sequencer placed in front of the conv-encoder / channel / Viterbi-decoder chain.
- Buffers one FRAME_LEN-bit frame from a requester using a valid/ready handshake.
- Streams the frame into the encoder continuously, appends TAIL_LEN zero flush bits, then keeps clocking zeros until decoding completes.
- Aligns decoder output to the input using a fixed DEC_LAT and outputs the decoded bits.
- Counts bit mismatches against the buffered frame.

---
 rtl/viterbi_frame_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
// Frame sequencer for the conv-encoder / channel / Viterbi-decoder chain.
// It buffers one FRAME_LEN-bit frame from a valid/ready source and streams it
// into the encoder. It then appends TAIL_LEN zero flush bits and keeps clocking
// zeros until the decoder has delivered every data bit. Decoder output is
// aligned to the buffered frame using a fixed DEC_LAT, and bit mismatches are
// counted.
//
// Optional build macro: CUM_STATS_EN
//   defined   : frame_count_o counts completed frames (saturating), and
//               err_count_o accumulates across frames until reset.
//   undefined : frame_count_o is tied to 0, and err_count_o restarts on each
//               accepted start_i.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   start_i        begin a new frame (sampled in IDLE only)
//   busy_o         high in every state except IDLE
//   src_valid_i    source bit valid
//   src_data_i     source bit
//   src_ready_o    high in FILL only
//   enc_data_o     bit to the encoder
//   enc_enable_o   encoder clock enable
//   dec_data_i     bit from the decoder
//   out_valid_o    decoded bit valid (registered)
//   out_data_o     decoded bit (registered)
//   done_o         one-cycle pulse when a frame completes
//   err_count_o    mismatch count (saturating)
//   frame_count_o  completed-frame count (CUM_STATS_EN only, else 0)

module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             busy_o,
    input  logic             src_valid_i,
    input  logic             src_data_i,
    output logic             src_ready_o,
    output logic             enc_data_o,
    output logic             enc_enable_o,
    input  logic             dec_data_i,
    output logic             out_valid_o,
    output logic             out_data_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] frame_count_o
);

    localparam int CYC_W   = $clog2(DEC_LAT + FRAME_LEN + TAIL_LEN + 1);
    localparam int IDX_W   = $clog2(FRAME_LEN + 1);
    localparam int BUF_IW  = $clog2(FRAME_LEN);
    localparam int CAP_END = DEC_LAT + FRAME_LEN - 1;
    localparam int STR_END = FRAME_LEN + TAIL_LEN - 1;
    // The run ends at whichever finishes later: the capture window or the
    // encoder data+tail stream. This keeps the tail bits from being skipped.
    localparam int RUN_END = (CAP_END > STR_END) ? CAP_END : STR_END;

    localparam logic [CYC_W-1:0] SEND_LAST = CYC_W'(FRAME_LEN - 1);
    localparam logic [CYC_W-1:0] TAIL_LAST = CYC_W'(STR_END);
    localparam logic [CYC_W-1:0] CAP_FIRST = CYC_W'(DEC_LAT);
    localparam logic [CYC_W-1:0] CAP_LAST  = CYC_W'(CAP_END);
    localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(RUN_END);
    localparam logic [CYC_W-1:0] DATA_CYCS = CYC_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SEND,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_LEN-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_data_q, out_data_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic                 active;
    logic                 capture;
    logic [BUF_IW-1:0]    k_idx;
`ifdef CUM_STATS_EN
    logic [CNT_W-1:0]     frame_q, frame_d;
`endif

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        cyc_d       = cyc_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_data_d  = 1'b0;
        enc_data_o  = 1'b0;
        k_idx       = BUF_IW'(cyc_q - CAP_FIRST);

        active       = (state_q == S_SEND) || (state_q == S_TAIL) || (state_q == S_DRAIN);
        busy_o       = (state_q != S_IDLE);
        src_ready_o  = (state_q == S_FILL);
        enc_enable_o = active;
        done_o       = (state_q == S_DONE);

        // Buffered data goes out first; flush and drain cycles send zeros.
        if (active && (cyc_q < DATA_CYCS)) begin
            enc_data_o = buf_q[cyc_q[BUF_IW-1:0]];
        end

        // The capture window depends only on cyc. It may therefore overlap
        // SEND or TAIL when the decoder latency is short.
        capture = active && (cyc_q >= CAP_FIRST) && (cyc_q <= CAP_LAST);
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_data_i;
            if ((dec_data_i != buf_q[k_idx]) && (err_q != '1)) begin
                err_d = err_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FILL;
                    idx_d   = '0;
                    cyc_d   = '0;
`ifndef CUM_STATS_EN
                    err_d   = '0;
`endif
                end
            end
            S_FILL: begin
                if (src_valid_i) begin
                    buf_d[idx_q[BUF_IW-1:0]] = src_data_i;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_SEND;
                        cyc_d   = '0;
                    end
                end
            end
            S_SEND: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == RUN_LAST) begin
                    state_d = S_DONE;
                end else if (cyc_q == SEND_LAST) begin
                    state_d = (TAIL_LEN > 0) ? S_TAIL : S_DRAIN;
                end
            end
            S_TAIL: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == RUN_LAST) begin
                    state_d = S_DONE;
                end else if (cyc_q == TAIL_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == RUN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CUM_STATS_EN
    always_comb begin
        frame_d = frame_q;
        if ((state_q == S_DONE) && (frame_q != '1)) begin
            frame_d = frame_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_count_o = frame_q;
`else
    assign frame_count_o = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            idx_q       <= '0;
            cyc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            cyc_q       <= cyc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_count_o = err_q;

endmodule
